riscv_muldiv_iter: RTL and testbench

- Iterative multiply/divide unit implementing the RV32M/RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU for a parametrised XLEN.
- Sits beside the single-cycle ALU as the next-generation execute resource.
- The core issues one operation with a start pulse, stalls on busy, and captures the result on a one-cycle done pulse.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/riscv_muldiv_iter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_riscv_muldiv_iter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_muldiv_iter
// Purpose  : Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add
//            multiply and restoring divide, one bit per cycle.
//            Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
//            Divide-by-zero and signed overflow finish in one cycle.
// Optional : `define MULDIV_EARLY_OUT_EN adds two more one-cycle cases:
//            a multiply with a zero operand magnitude, and a divide
//            with |a| < |b|.
// Ports    : clk     - rising-edge clock
//            reset   - asynchronous active-low reset
//            start   - operation request, sampled only in IDLE
//            kill    - abort any in-flight operation
//            funct3  - M-extension operation select
//            a, b    - rs1 / rs2 operands
//            busy    - high while iterating (CALC) or sign-fixing (FIX)
//            done    - one-cycle pulse, result valid in the same cycle
//            result  - held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module riscv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);
    localparam logic [XLEN-1:0]  c_min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_all_ones = {XLEN{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic                r_neg;
    // Multiply: {high, low} product; low half starts as |b| and shifts out.
    // Divide  : high half is the partial remainder, low half starts as |a|
    //           and is progressively replaced by quotient bits.
    logic [2*XLEN-1:0]   r_prod;
    // |a| for multiply (multiplicand), |b| for divide (divisor).
    logic [XLEN-1:0]     r_opnd;
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_neg;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;
    logic            w_accept;

    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed & a[XLEN-1];
    assign w_b_neg    = w_b_signed & b[XLEN-1];
    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra width is needed.
    assign w_mag_a    = w_a_neg ? ({XLEN{1'b0}} - a) : a;
    assign w_mag_b    = w_b_neg ? ({XLEN{1'b0}} - b) : b;
    // Remainders follow the dividend's sign; everything else is the XOR.
    assign w_neg      = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = w_is_div && (b == {XLEN{1'b0}});
    assign w_div_ovf  = w_is_div && !funct3[0] && (a == c_min_neg) &&
                        (b == c_all_ones);
    assign w_accept   = (r_state == S_IDLE) && start && !kill;

    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_fast        = 1'b1;
            w_fast_result = funct3[1] ? a : c_all_ones;
        end else if (w_div_ovf) begin
            w_fast        = 1'b1;
            w_fast_result = funct3[1] ? {XLEN{1'b0}} : a;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!w_is_div &&
                 ((w_mag_a == {XLEN{1'b0}}) || (w_mag_b == {XLEN{1'b0}}))) begin
            w_fast        = 1'b1;
            w_fast_result = {XLEN{1'b0}};
        end else if (w_is_div && (w_mag_a < w_mag_b)) begin
            w_fast        = 1'b1;
            w_fast_result = funct3[1] ? a : {XLEN{1'b0}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;

    // Add the multiplicand into the high half when the current multiplier
    // bit is set; the carry lands in the top bit of the shifted product.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                        (r_prod[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

    // Restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor only if it fits.
    assign w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_rem   = w_div_ok ? (w_div_shift[XLEN-1:0] - r_opnd)
                                  : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_prod[XLEN-2:0], w_div_ok};

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_mul_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_mul_fix = r_neg ? ({(2*XLEN){1'b0}} - r_prod) : r_prod;
    assign w_quo_fix = r_neg ? ({XLEN{1'b0}} - r_prod[XLEN-1:0])
                             : r_prod[XLEN-1:0];
    assign w_rem_fix = r_neg ? ({XLEN{1'b0}} - r_prod[2*XLEN-1:XLEN])
                             : r_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = {XLEN{1'b0}};
        case (r_funct3)
            3'b000:                 w_fix_result = w_mul_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_mul_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_quo_fix;
            default:                w_fix_result = w_rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // kill and start are both ignored here.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_funct3 <= 3'b000;
            r_neg    <= 1'b0;
            r_prod   <= {(2*XLEN){1'b0}};
            r_opnd   <= {XLEN{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_neg    <= w_neg;
                        r_cnt    <= c_cnt_init;
                        if (w_is_div) begin
                            r_prod <= {{XLEN{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_prod <= {{XLEN{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                        if (w_fast) begin
                            r_result <= w_fast_result;
                        end
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        r_prod <= r_funct3[2] ? w_div_next : w_mul_next;
                        if (r_cnt != c_cnt_last) begin
                            r_cnt <= r_cnt - c_cnt_last;
                        end
                    end
                end
                S_FIX: begin
                    // Result is written on the way into DONE so it is valid
                    // alongside done; a kill here leaves it untouched.
                    if (!kill) begin
                        r_result <= w_fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_muldiv_iter
// Purpose  : Self-checking bench for riscv_muldiv_iter (XLEN=32). A vector
//            table drives operations; expected results are queued at issue
//            and compared when done pulses. Hand-written sequences cover
//            kill, start-while-busy, start-in-DONE and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_iter;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = XLEN + 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    riscv_muldiv_iter #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] av;
        logic [XLEN-1:0] bv;
        logic [XLEN-1:0] exp;
        bit              fast;  // divide-by-zero / overflow path
        bit              eo;    // qualifies for the optional early-out
    } vec_t;

    vec_t            vecs[$];
    logic [XLEN-1:0] sb_q[$];
    logic [XLEN-1:0] last_result;
    int              n_checks;
    int              n_errors;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] f, input logic [XLEN-1:0] av,
                                 input logic [XLEN-1:0] bv,
                                 input logic [XLEN-1:0] exp,
                                 input bit fast, input bit eo);
        mkv.f    = f;
        mkv.av   = av;
        mkv.bv   = bv;
        mkv.exp  = exp;
        mkv.fast = fast;
        mkv.eo   = eo;
    endfunction

    function automatic int exp_latency(input bit fast, input bit eo);
        if (fast) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (eo) return 1;
`endif
        return NORMAL_LAT;
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("result", result, sb_q.pop_front());
            end
        end
    end

    // Issue one operation and wait for its done. With poke set, a start is
    // pulsed mid-calculation and again during the DONE cycle; both must be
    // ignored.
    task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] av,
                          input logic [XLEN-1:0] bv, input logic [XLEN-1:0] exp,
                          input int exp_lat, input bit poke);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        funct3 = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        sb_q.push_back(exp);
        last_result = exp;
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        funct3   = 3'($urandom_range(0, 7));
        lat      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                start = poke && (lat == 5);
                if (start) begin
                    funct3 = 3'b101;
                    a      = 32'd100;
                    b      = 32'd7;
                end
                lat++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end else begin
            check("latency", lat, exp_lat);
            check("busy_cycles", busy_cnt, exp_lat - 1);
            if (poke) begin
                funct3 = 3'b101;
                a      = 32'd5;
                b      = 32'd0;
                start  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_in_done_busy", busy, 0);
                check("start_in_done_done", done, 0);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        last_result = '0;
        reset       = 1'b0;
        start       = 1'b0;
        kill        = 1'b0;
        funct3      = 3'b000;
        a           = '0;
        b           = '0;

        vecs.push_back(mkv(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0));
        vecs.push_back(mkv(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0));
        vecs.push_back(mkv(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mkv(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mkv(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0));
        vecs.push_back(mkv(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0));
        vecs.push_back(mkv(3'b011, 32'hFFFFFFFF, 32'd2,        32'h00000001, 0, 0));
        vecs.push_back(mkv(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0));
        vecs.push_back(mkv(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0));
        vecs.push_back(mkv(3'b101, 32'd100,      32'd7,        32'd14,       0, 0));
        vecs.push_back(mkv(3'b111, 32'd100,      32'd7,        32'd2,        0, 0));
        vecs.push_back(mkv(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0));
        vecs.push_back(mkv(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 0));
        vecs.push_back(mkv(3'b100, 32'h80000000, 32'd2,        32'hC0000000, 0, 0));
        vecs.push_back(mkv(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0));
        vecs.push_back(mkv(3'b110, 32'd5,        32'd0,        32'd5,        1, 0));
        vecs.push_back(mkv(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0));
        vecs.push_back(mkv(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0));
        vecs.push_back(mkv(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1));
        vecs.push_back(mkv(3'b000, 32'd0,        32'h00001234, 32'd0,        0, 1));
        vecs.push_back(mkv(3'b111, 32'd3,        32'd10,       32'd3,        0, 1));
        vecs.push_back(mkv(3'b110, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFD, 0, 1));

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].av, vecs[i].bv, vecs[i].exp,
                   exp_latency(vecs[i].fast, vecs[i].eo), 1'b0);
        end

        // Start pulses while busy and during DONE are ignored.
        run_op(3'b000, 32'd3, 32'd4, 32'd12, NORMAL_LAT, 1'b1);

        // kill together with start in IDLE: start ignored.
        @(negedge clk);
        funct3 = 3'b101; a = 32'd5; b = 32'd0; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", busy, 0);
        check("kill_start_done", done, 0);

        // Kill a DIV mid-calculation.
        funct3 = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check("kill_busy_before", busy, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_after", busy, 0);
        check("kill_done_after", done, 0);
        repeat (40) @(negedge clk);
        check("kill_result_held", result, last_result);
        check("kill_idle", busy, 0);

        // Asynchronous reset mid-CALC.
        funct3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        check("async_reset_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, NORMAL_LAT, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
